// File: rtl/seven_segment_capture_if.sv
// Seven-segment display bus as seen by the capture block: the multiplexed
// segment/strobe inputs plus the recovered frame outputs.
interface seven_segment_capture_if #(
  parameter int w_digit = 2
);
  logic [7:0]           abcdefgh;
  logic [w_digit-1:0]   digit;
  logic [w_digit*4-1:0] number;
  logic [w_digit-1:0]   dots;
  logic                 valid;
  logic                 frame_error;

  modport master (
    output abcdefgh, digit,
    input  number, dots, valid, frame_error
  );

  modport slave (
    input  abcdefgh, digit,
    output number, dots, valid, frame_error
  );
endinterface

// File: rtl/seven_segment_capture.sv
// Recovers the hex number and dot vector shown on a multiplexed
// seven-segment bus. Each digit is sampled once its strobe and segments have
// held steady for settle_cycles cycles; a full set of digits is published as
// a frame with a one-cycle valid pulse, or flagged with frame_error when any
// glyph in it could not be decoded.
module seven_segment_capture #(
  parameter int w_digit       = 2,
  parameter int settle_cycles = 4
) (
  input logic clk,
  input logic rst,
  seven_segment_capture_if.slave bus
);

  localparam int cnt_w = $clog2(settle_cycles + 1);
  localparam int idx_w = $clog2(w_digit);
  localparam logic [cnt_w-1:0] settle_max = cnt_w'(settle_cycles);

  // Returns {illegal, nibble}; segments are a..g with a in the MSB.
  function automatic logic [4:0] decode_glyph(input logic [6:0] g);
    logic [4:0] r;
    case (g)
      7'b1111110: r = 5'h00;
      7'b0110000: r = 5'h01;
      7'b1101101: r = 5'h02;
      7'b1111001: r = 5'h03;
      7'b0110011: r = 5'h04;
      7'b1011011: r = 5'h05;
      7'b1011111: r = 5'h06;
      7'b1110000: r = 5'h07;
      7'b1111111: r = 5'h08;
      7'b1110011: r = 5'h09;
      7'b1110111: r = 5'h0A;
      7'b0011111: r = 5'h0B;
      7'b1001110: r = 5'h0C;
      7'b0111101: r = 5'h0D;
      7'b1001111: r = 5'h0E;
      7'b1000111: r = 5'h0F;
      default:    r = 5'h10;
    endcase
    return r;
  endfunction

  // Position of the set bit of a one-hot strobe.
  function automatic logic [idx_w-1:0] onehot_index(input logic [w_digit-1:0] d);
    logic [idx_w-1:0] idx;
    idx = '0;
    for (int i = 0; i < w_digit; i++) begin
      if (d[i]) idx = idx_w'(i);
    end
    return idx;
  endfunction

  logic [w_digit-1:0]   digit_p0;
  logic [7:0]           seg_p0;
  logic [cnt_w-1:0]     cnt_p0;
  logic [w_digit*4-1:0] shadow_number;
  logic [w_digit-1:0]   shadow_dots;
  logic [w_digit-1:0]   seen;
  logic                 bad;
  logic [w_digit*4-1:0] frame_number;
  logic [w_digit-1:0]   frame_dots;
  logic                 vld_p1;
  logic                 err_p1;

  logic [w_digit-1:0]   digit_dec;
  logic                 is_onehot;
  logic                 same;
  logic [cnt_w-1:0]     cnt_next;
  logic                 capture;
  logic [4:0]           glyph;
  logic [idx_w-1:0]     idx;
  logic [w_digit-1:0]   seen_bit;
  logic                 frame_done;
  logic [w_digit-1:0]   seen_base;
  logic                 bad_base;

  // Dwell tracking against the previous sample and the capture decision.
  always_comb begin
    digit_dec  = bus.digit - w_digit'(1);
    is_onehot  = (bus.digit != '0) && ((bus.digit & digit_dec) == '0);
    same       = (bus.digit == digit_p0) && (bus.abcdefgh == seg_p0);
    cnt_next   = '0;
    capture    = 1'b0;
    glyph      = decode_glyph(bus.abcdefgh[7:1]);
    idx        = onehot_index(bus.digit);
    seen_bit   = '0;
    seen_bit[idx] = 1'b1;
    frame_done = &seen;
    seen_base  = frame_done ? '0 : seen;
    bad_base   = frame_done ? 1'b0 : bad;
    if (is_onehot) begin
      if (!same)                    cnt_next = cnt_w'(1);
      else if (cnt_p0 == settle_max) cnt_next = settle_max;
      else                          cnt_next = cnt_p0 + cnt_w'(1);
      // Fires only on the cycle the count first reaches the settle length.
      capture = (cnt_next == settle_max) && !(same && (cnt_p0 == settle_max));
    end
  end

  // Stage p0: previous-sample registers, dwell counter, frame bookkeeping and
  // the registered p1 publish/error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      digit_p0     <= '0;
      seg_p0       <= '0;
      cnt_p0       <= '0;
      seen         <= '0;
      bad          <= 1'b0;
      frame_number <= '0;
      frame_dots   <= '0;
      vld_p1       <= 1'b0;
      err_p1       <= 1'b0;
    end else begin
      digit_p0 <= bus.digit;
      seg_p0   <= bus.abcdefgh;
      cnt_p0   <= cnt_next;
      vld_p1   <= frame_done && !bad;
      err_p1   <= frame_done && bad;
      if (frame_done && !bad) begin
        frame_number <= shadow_number;
        frame_dots   <= shadow_dots;
      end
      // A capture on the completing edge seeds the next frame.
      if (capture) begin
        seen <= seen_base | seen_bit;
        bad  <= bad_base | glyph[4];
      end else begin
        seen <= seen_base;
        bad  <= bad_base;
      end
    end
  end

  // Shadow frame under construction; an illegal glyph stores zero.
  always_ff @(posedge clk) begin
    if (capture) begin
      shadow_number[int'(idx)*4 +: 4] <= glyph[4] ? 4'h0 : glyph[3:0];
      shadow_dots[idx]                <= bus.abcdefgh[0];
    end
  end

  assign bus.number      = frame_number;
  assign bus.dots        = frame_dots;
  assign bus.valid       = vld_p1;
  assign bus.frame_error = err_p1;

endmodule

// File: tb/tb_seven_segment_capture.sv
// Directed bench for seven_segment_capture with two digits and a settle
// length of four cycles.
module tb_seven_segment_capture;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  int   valid_total;
  int   err_total;
  int   both_total;

  // Bench-side glyph table, index = hex value, a in the MSB.
  logic [6:0] enc_tab [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1110011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  seven_segment_capture_if #(.w_digit(2)) bus ();

  seven_segment_capture #(.w_digit(2), .settle_cycles(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters: at each rising edge, count the output level of the cycle just ended.
  always @(posedge clk) begin
    if (bus.valid === 1'b1) valid_total++;
    if (bus.frame_error === 1'b1) err_total++;
    if (bus.valid === 1'b1 && bus.frame_error === 1'b1) both_total++;
  end

  task automatic hold(input logic [1:0] d, input logic [7:0] s, input int n);
    bus.digit    = d;
    bus.abcdefgh = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_reset();
    rst          = 1'b1;
    bus.digit    = 2'b00;
    bus.abcdefgh = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    bus.digit    = 2'b11;
    bus.abcdefgh = 8'hFF;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bus.number !== 8'h00) begin n_bad++; $display("FAIL reset_number got %h want 00", bus.number); end
    n_cmp++;
    if (bus.dots !== 2'b00) begin n_bad++; $display("FAIL reset_dots got %b want 00", bus.dots); end
    n_cmp++;
    if (bus.valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", bus.valid); end
    n_cmp++;
    if (bus.frame_error !== 1'b0) begin n_bad++; $display("FAIL reset_frame_error got %b want 0", bus.frame_error); end
    rst = 1'b0;
  endtask

  task automatic test_basic_frame();
    int v0;
    int e0;
    logic exp_v;
    apply_reset();
    v0 = valid_total;
    e0 = err_total;
    hold(2'b01, 8'hF2, 6);
    bus.digit    = 2'b10;
    bus.abcdefgh = 8'h67;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      exp_v = (c == 5);
      n_cmp++;
      if (bus.valid !== exp_v) begin
        n_bad++;
        $display("FAIL basic_valid_timing cycle %0d got %b want %b", c, bus.valid, exp_v);
      end
    end
    hold(2'b00, 8'h00, 2);
    n_cmp++;
    if (bus.number !== 8'h43) begin n_bad++; $display("FAIL basic_number got %h want 43", bus.number); end
    n_cmp++;
    if (bus.dots !== 2'b10) begin n_bad++; $display("FAIL basic_dots got %b want 10", bus.dots); end
    n_cmp++;
    if (valid_total - v0 !== 1) begin n_bad++; $display("FAIL basic_valid_count got %0d want 1", valid_total - v0); end
    n_cmp++;
    if (err_total - e0 !== 0) begin n_bad++; $display("FAIL basic_error_count got %0d want 0", err_total - e0); end
  endtask

  task automatic test_short_dwell();
    int v0;
    apply_reset();
    v0 = valid_total;
    for (int r = 0; r < 4; r++) begin
      hold(2'b01, 8'hF2, 3);
      hold(2'b10, 8'h67, 3);
    end
    hold(2'b00, 8'h00, 3);
    n_cmp++;
    if (valid_total - v0 !== 0) begin n_bad++; $display("FAIL short_dwell_valid got %0d want 0", valid_total - v0); end
    n_cmp++;
    if (bus.number !== 8'h00) begin n_bad++; $display("FAIL short_dwell_number got %h want 00", bus.number); end
    // A dwell of exactly the settle length is enough.
    hold(2'b01, 8'hF2, 4);
    hold(2'b10, 8'h67, 4);
    hold(2'b00, 8'h00, 3);
    n_cmp++;
    if (valid_total - v0 !== 1) begin n_bad++; $display("FAIL exact_dwell_valid got %0d want 1", valid_total - v0); end
    n_cmp++;
    if (bus.number !== 8'h43) begin n_bad++; $display("FAIL exact_dwell_number got %h want 43", bus.number); end
  endtask

  task automatic test_illegal_glyph();
    int v0;
    int e0;
    apply_reset();
    v0 = valid_total;
    e0 = err_total;
    hold(2'b01, 8'h02, 6);
    hold(2'b10, 8'hB6, 6);
    hold(2'b00, 8'h00, 3);
    n_cmp++;
    if (err_total - e0 !== 1) begin n_bad++; $display("FAIL illegal_error_count got %0d want 1", err_total - e0); end
    n_cmp++;
    if (valid_total - v0 !== 0) begin n_bad++; $display("FAIL illegal_valid_count got %0d want 0", valid_total - v0); end
    n_cmp++;
    if (bus.number !== 8'h00 || bus.dots !== 2'b00) begin
      n_bad++; $display("FAIL illegal_hold got %h/%b want 00/00", bus.number, bus.dots);
    end
    hold(2'b01, 8'hE0, 6);
    hold(2'b10, 8'h9E, 6);
    hold(2'b00, 8'h00, 3);
    n_cmp++;
    if (valid_total - v0 !== 1) begin n_bad++; $display("FAIL recover_valid_count got %0d want 1", valid_total - v0); end
    n_cmp++;
    if (bus.number !== 8'hE7) begin n_bad++; $display("FAIL recover_number got %h want e7", bus.number); end
    n_cmp++;
    if (err_total - e0 !== 1) begin n_bad++; $display("FAIL recover_error_count got %0d want 1", err_total - e0); end
  endtask

  task automatic test_idle_strobe();
    int v0;
    apply_reset();
    v0 = valid_total;
    hold(2'b01, 8'hDA, 6);
    hold(2'b00, 8'hDA, 10);
    hold(2'b11, 8'hDA, 10);
    n_cmp++;
    if (valid_total - v0 !== 0) begin n_bad++; $display("FAIL idle_early_valid got %0d want 0", valid_total - v0); end
    hold(2'b10, 8'hBE, 6);
    hold(2'b00, 8'h00, 3);
    n_cmp++;
    if (valid_total - v0 !== 1) begin n_bad++; $display("FAIL idle_valid_count got %0d want 1", valid_total - v0); end
    n_cmp++;
    if (bus.number !== 8'h62) begin n_bad++; $display("FAIL idle_number got %h want 62", bus.number); end
  endtask

  task automatic test_overwrite();
    int v0;
    apply_reset();
    v0 = valid_total;
    hold(2'b01, 8'h60, 6);
    hold(2'b01, 8'hE6, 6);
    n_cmp++;
    if (valid_total - v0 !== 0) begin n_bad++; $display("FAIL overwrite_early_valid got %0d want 0", valid_total - v0); end
    hold(2'b10, 8'hEE, 6);
    hold(2'b00, 8'h00, 3);
    n_cmp++;
    if (valid_total - v0 !== 1) begin n_bad++; $display("FAIL overwrite_valid_count got %0d want 1", valid_total - v0); end
    n_cmp++;
    if (bus.number !== 8'hA9) begin n_bad++; $display("FAIL overwrite_number got %h want a9", bus.number); end
  endtask

  task automatic test_mid_reset();
    int v0;
    apply_reset();
    hold(2'b01, 8'h60, 6);
    rst = 1'b1;
    bus.digit    = 2'b10;
    bus.abcdefgh = 8'hEE;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.valid !== 1'b0 || bus.number !== 8'h00) begin
        n_bad++; $display("FAIL mid_reset_outputs got %b/%h want 0/00", bus.valid, bus.number);
      end
    end
    rst = 1'b0;
    v0 = valid_total;
    hold(2'b10, 8'hEE, 10);
    hold(2'b00, 8'h00, 3);
    n_cmp++;
    if (valid_total - v0 !== 0) begin n_bad++; $display("FAIL mid_reset_partial got %0d want 0", valid_total - v0); end
    hold(2'b01, 8'h60, 6);
    hold(2'b00, 8'h00, 3);
    n_cmp++;
    if (valid_total - v0 !== 1) begin n_bad++; $display("FAIL mid_reset_valid got %0d want 1", valid_total - v0); end
    n_cmp++;
    if (bus.number !== 8'hA1) begin n_bad++; $display("FAIL mid_reset_number got %h want a1", bus.number); end
  endtask

  task automatic test_loopback();
    int v0;
    int e0;
    logic [3:0] nib;
    logic       dot;
    apply_reset();
    v0 = valid_total;
    e0 = err_total;
    for (int r = 0; r < 6; r++) begin
      for (int d = 0; d < 2; d++) begin
        nib = (d == 0) ? 4'hC : 4'h5;
        dot = (d == 0);
        hold(2'(1 << d), {enc_tab[nib], dot}, 8);
      end
    end
    hold(2'b00, 8'h00, 3);
    n_cmp++;
    if (valid_total - v0 !== 6) begin n_bad++; $display("FAIL loopback_valid_count got %0d want 6", valid_total - v0); end
    n_cmp++;
    if (bus.number !== 8'h5C) begin n_bad++; $display("FAIL loopback_number got %h want 5c", bus.number); end
    n_cmp++;
    if (bus.dots !== 2'b01) begin n_bad++; $display("FAIL loopback_dots got %b want 01", bus.dots); end
    n_cmp++;
    if (err_total - e0 !== 0) begin n_bad++; $display("FAIL loopback_error_count got %0d want 0", err_total - e0); end
  endtask

  initial begin
    n_cmp        = 0;
    n_bad        = 0;
    valid_total  = 0;
    err_total    = 0;
    both_total   = 0;
    rst          = 1'b1;
    bus.digit    = 2'b00;
    bus.abcdefgh = 8'h00;
    @(negedge clk);
    test_reset();
    test_basic_frame();
    test_short_dwell();
    test_illegal_glyph();
    test_idle_strobe();
    test_overwrite();
    test_mid_reset();
    test_loopback();
    n_cmp++;
    if (both_total !== 0) begin n_bad++; $display("FAIL valid_with_error got %0d want 0", both_total); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seven_segment_capture.md
Name: seven_segment_capture

Overview:
- Receive-side counterpart of the multiplexed seven-segment driver: monitors the abcdefgh/digit bus and recovers the displayed hex number and dot vector.
- Samples each digit after its strobe and segments have been stable, decodes the glyph back to a nibble, and assembles a full frame.
- Publishes the frame with a one-cycle valid pulse.
- Used as a loopback checker in self-test builds and to read displays driven by another board.

Parameters:
- w_digit, 2, number of multiplexed digits; must be >= 2.
- settle_cycles, 4, consecutive identical cycles required before a digit is sampled; must be >= 1.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- abcdefgh  input  8  segment bus; bit 7 = a ... bit 1 = g, bit 0 = h (dot); active-high.
- digit  input  w_digit  digit strobe; one-hot, active-high.
- number  output  w_digit*4  last good frame; digit i in bits [4i+3:4i].
- dots  output  w_digit  last good frame dot bits.
- valid  output  1  one-cycle pulse when number/dots update.
- frame_error  output  1  one-cycle pulse when a completed frame held an undecodable glyph.

Behaviour:
- Reset: number=0, dots=0, valid=0, frame_error=0; seen mask, bad flag and dwell counter cleared; previous-sample registers cleared.
- Glyph decode on abcdefgh[7:1], ignoring h:
  - 0:1111110, 1:0110000, 2:1101101, 3:1111001
  - 4:0110011, 5:1011011, 6:1011111, 7:1110000
  - 8:1111111, 9:1110011, A:1110111, b:0011111
  - C:1001110, d:0111101, E:1001111, F:1000111
  - Any other pattern, including all-zero, is illegal.
- Idle strobe: digit not exactly one-hot (zero or multi-hot) is idle. Dwell counter holds at 0, nothing captured, seen/bad state unchanged.
- Dwell tracking:
  - Inputs {digit, abcdefgh} are registered every cycle.
  - A dwell is a run of consecutive cycles with identical values and one-hot digit.
  - The counter restarts at 1 on any change and saturates at settle_cycles.
- Capture:
  - Occurs exactly once per dwell, at the edge ending the dwell's settle_cycles-th cycle. For settle_cycles=1 this is the first cycle of the dwell.
  - Dwells shorter than settle_cycles are discarded.
- On capture of index i:
  - shadow nibble[i] <= decoded value, or 0 if illegal.
  - shadow dot[i] <= h.
  - seen[i] <= 1.
  - bad <= bad | illegal.
  - A repeat capture of an index already seen in the current frame overwrites it with no error, and may clear that index's contribution only by rewriting it; bad stays sticky within the frame.
- Frame completion: when a capture makes seen all-ones, at the next edge:
  - If no glyph in the frame was illegal, including the completing one: number/dots <= shadow values including the completing digit, and valid=1 for exactly one cycle.
  - Otherwise number/dots hold, and frame_error=1 for exactly one cycle.
  - In both cases seen and bad clear in the same edge.
- Latency: valid asserts 1 cycle after the completing capture edge, i.e. settle_cycles+1 cycles after the completing digit's dwell begins, counting the register stage.
- valid and frame_error are never asserted together. Outputs are registered.
- A capture on the same edge that completes a frame starts the next frame (seen = that index only) while the completed frame is published.
- Mid-operation reset discards any partial frame; the first post-reset frame requires every digit to be re-captured.
- Segment changes within one strobe (driver refresh mid-dwell) start a new dwell. The later value overwrites if it also settles.

Test Plan:
- Reset, then w_digit=2, settle 4: present digit=01, abcdefgh=1111_0010 (3) for 6 cycles, then digit=10, abcdefgh=0110_0111 (4 with dot) for 6 cycles -> valid pulses once, 1 cycle after the 4th cycle of digit 10; number=0x43, dots=2'b10.
- Dwells of 3 cycles each alternating digit 01/10 with valid glyphs -> no capture, valid never asserts, number stays 0.
- digit 01 with abcdefgh=0000_0010, then digit 10 with valid 5 -> frame_error pulses once, valid=0, number/dots unchanged; following clean frame of 7,E -> valid, number=0xE7.
- digit=00 and digit=11, each held 10 cycles between two good captures -> ignored; frame completes normally with the correct values.
- Capture digit 01 as 1, then digit 01 again as 9 (new dwell), then digit 10 as A -> number=0xA9 on a single valid pulse.
- Assert rst after digit 01 captured, release, present only digit 10 -> no valid until digit 01 is captured again; outputs stay 0 through reset.
- Loopback with the seven-segment driver (clk_mhz scaled small), driving number 0x5C dots 01 -> number=0x5C, dots=01 with repeated valid pulses.
